// File: rtl/rect_plotter.sv
// rect_plotter: fills one clipped rectangle per request, emitting one pixel
// per clock (row-major) on x/y/colour/plot, then pulses done for one cycle.
module rect_plotter #(
  parameter int SCREEN_W = 160,
  parameter int SCREEN_H = 120
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [7:0] req_x,
  input  logic [6:0] req_y,
  input  logic [7:0] req_w,
  input  logic [6:0] req_h,
  input  logic [2:0] req_colour,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot,
  output logic       done
);

  localparam logic [8:0] SW9 = 9'(SCREEN_W);
  localparam logic [7:0] SH8 = 8'(SCREEN_H);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_DRAW = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state;
  state_t     state_nxt;

  // Latched request geometry, stable for the whole draw
  logic [7:0] x_left;
  logic [7:0] x_end;
  logic [6:0] y_end;

  logic [8:0] x_sum;
  logic [7:0] y_sum;
  logic [7:0] x_end_nxt;
  logic [6:0] y_end_nxt;
  logic       req_empty;
  logic       accept;
  logic       last_px;

  // Clipped bounds: right/bottom edge is min(origin+size, screen) - 1.
  // Sums are widened so that 255+255 and 127+127 cannot wrap.
  assign x_sum     = {1'b0, req_x} + {1'b0, req_w};
  assign y_sum     = {1'b0, req_y} + {1'b0, req_h};
  assign x_end_nxt = (x_sum > SW9) ? 8'(SCREEN_W - 1) : 8'(x_sum - 9'd1);
  assign y_end_nxt = (y_sum > SH8) ? 7'(SCREEN_H - 1) : 7'(y_sum - 8'd1);

  // Nothing visible to draw: zero size or origin entirely off-screen
  assign req_empty = (req_w == 8'd0) || (req_h == 7'd0) ||
                     ({1'b0, req_x} >= SW9) || ({1'b0, req_y} >= SH8);

  assign accept  = req_valid && (state == S_IDLE);
  assign last_px = (x == x_end) && (y == y_end);

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state decode
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: if (accept) state_nxt = req_empty ? S_DONE : S_DRAW;
      S_DRAW: if (last_px) state_nxt = S_DONE;
      S_DONE: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Handshake output decoded straight from the state register
  always_comb begin
    req_ready = (state == S_IDLE);
  end

  // Registered pixel stream and completion strobe
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      x      <= 8'd0;
      y      <= 7'd0;
      colour <= 3'd0;
      plot   <= 1'b0;
      done   <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (accept) begin
            if (req_empty) begin
              plot <= 1'b0;
              done <= 1'b1;
            end else begin
              x      <= req_x;
              y      <= req_y;
              colour <= req_colour;
              plot   <= 1'b1;
            end
          end
        end
        S_DRAW: begin
          if (last_px) begin
            plot <= 1'b0;
            done <= 1'b1;
          end else if (x != x_end) begin
            x <= x + 8'd1;
          end else begin
            x <= x_left;
            y <= y + 7'd1;
          end
        end
        S_DONE: begin
          done <= 1'b0;
          plot <= 1'b0;
        end
        default: begin
          done <= 1'b0;
          plot <= 1'b0;
        end
      endcase
    end
  end

  // Geometry latch; only meaningful while drawing, so it carries no reset
  always_ff @(posedge clock) begin
    if (accept) begin
      x_left <= req_x;
      x_end  <= x_end_nxt;
      y_end  <= y_end_nxt;
    end
  end

endmodule

// File: tb/tb_rect_plotter.sv
// Bench for rect_plotter: a pixel scoreboard fed by a reference fill model,
// plus per-request handshake timing checks.
module tb_rect_plotter;

  logic       clock;
  logic       reset;
  logic       req_valid;
  logic       req_ready;
  logic [7:0] req_x;
  logic [6:0] req_y;
  logic [7:0] req_w;
  logic [6:0] req_h;
  logic [2:0] req_colour;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  logic       plot;
  logic       done;

  int n_checks = 0;
  int n_fail   = 0;

  logic [17:0] exp_q[$];

  rect_plotter #(.SCREEN_W(160), .SCREEN_H(120)) dut (
    .clock(clock), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .req_w(req_w), .req_h(req_h),
    .req_colour(req_colour),
    .x(x), .y(y), .colour(colour), .plot(plot), .done(done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference model: push every on-screen pixel of the request, row-major
  task automatic push_rect(input int rx, input int ry, input int rw, input int rh,
                           input int rc, output int n);
    int xe, ye;
    n = 0;
    if (rw == 0 || rh == 0 || rx >= 160 || ry >= 120) return;
    xe = ((rx + rw) < 160 ? (rx + rw) : 160) - 1;
    ye = ((ry + rh) < 120 ? (ry + rh) : 120) - 1;
    for (int yy = ry; yy <= ye; yy++)
      for (int xx = rx; xx <= xe; xx++) begin
        exp_q.push_back({8'(xx), 7'(yy), 3'(rc)});
        n++;
      end
  endtask

  // Pixel monitor: every plot cycle consumes one expected pixel
  always @(negedge clock) begin
    if (plot) begin
      check("x_on_screen", {31'd0, (x < 8'd160)}, 32'd1);
      check("y_on_screen", {31'd0, (y < 7'd120)}, 32'd1);
      if (exp_q.size() == 0) begin
        check("unexpected_pixel", {14'd0, x, y, colour}, 32'h3ffff);
      end else begin
        logic [17:0] e;
        e = exp_q.pop_front();
        check("pixel", {14'd0, x, y, colour}, {14'd0, e});
      end
    end
  end

  // Cycle-accurate shape of one request after its accept edge
  task automatic expect_run(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clock);
      if (plot !== 1'b1 || req_ready !== 1'b0 || done !== 1'b0)
        check({tag, "_draw_ctl"}, {29'd0, plot, req_ready, done}, 32'b100);
    end
    @(negedge clock);
    check({tag, "_done_cyc"}, {29'd0, plot, req_ready, done}, 32'b001);
    @(negedge clock);
    check({tag, "_idle_cyc"}, {29'd0, plot, req_ready, done}, 32'b010);
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  // Drive one request from IDLE and check its full timing
  task automatic send(input string tag, input int rx, input int ry, input int rw,
                      input int rh, input int rc);
    int n;
    @(negedge clock);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
    req_x = 8'(rx); req_y = 7'(ry); req_w = 8'(rw); req_h = 7'(rh);
    req_colour = 3'(rc);
    req_valid = 1'b1;
    push_rect(rx, ry, rw, rh, rc, n);
    @(posedge clock);
    #1 req_valid = 1'b0;
    expect_run(tag, n);
  endtask

  initial begin
    int n;
    reset = 1'b1; req_valid = 1'b0;
    req_x = '0; req_y = '0; req_w = '0; req_h = '0; req_colour = '0;
    repeat (2) @(posedge clock);
    #1;
    check("rst_outs", {14'd0, x, y, colour}, 32'd0);
    check("rst_ctl", {29'd0, plot, req_ready, done}, 32'b010);
    @(negedge clock) reset = 1'b0;

    // Basic 3x2 fill
    send("t1", 10, 20, 3, 2, 3'b100);
    // Bottom-right clip
    send("t2", 158, 118, 5, 5, 3'b010);
    // Full-screen clear
    send("t3", 0, 0, 160, 120, 3'b000);
    // Degenerate requests
    send("t4w", 10, 10, 0, 5, 3'b111);
    send("t4h", 10, 10, 5, 0, 3'b111);
    send("t4x", 200, 10, 5, 5, 3'b111);
    send("t4y", 10, 120, 5, 5, 3'b111);

    // Busy input changes and back-to-back acceptance
    @(negedge clock);
    req_x = 8'd30; req_y = 7'd40; req_w = 8'd4; req_h = 7'd1; req_colour = 3'b001;
    req_valid = 1'b1;
    push_rect(30, 40, 4, 1, 1, n);
    @(posedge clock);
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      check("t5_busy_ready", {31'd0, req_ready}, 32'd0);
      req_x = 8'($urandom_range(0, 255)); req_y = 7'($urandom_range(0, 127));
      req_w = 8'($urandom_range(0, 255)); req_h = 7'($urandom_range(0, 127));
      req_colour = 3'($urandom_range(0, 7));
    end
    @(negedge clock);
    check("t5_done_cyc", {29'd0, plot, req_ready, done}, 32'b001);
    check("t5_first_sb", exp_q.size(), 0);
    req_x = 8'd50; req_y = 7'd60; req_w = 8'd2; req_h = 7'd1; req_colour = 3'b110;
    push_rect(50, 60, 2, 1, 6, n);
    @(negedge clock);
    check("t5_gap_idle", {29'd0, plot, req_ready, done}, 32'b010);
    @(posedge clock);
    #1 req_valid = 1'b0;
    expect_run("t5b", n);

    // Reset in the middle of an 8x8 draw
    @(negedge clock);
    req_x = 8'd0; req_y = 7'd0; req_w = 8'd8; req_h = 7'd8; req_colour = 3'b011;
    req_valid = 1'b1;
    push_rect(0, 0, 8, 8, 3, n);
    @(posedge clock);
    #1 req_valid = 1'b0;
    repeat (3) @(negedge clock);
    #2 reset = 1'b1;
    #1;
    check("t6_async_plot", {31'd0, plot}, 32'd0);
    check("t6_async_done", {31'd0, done}, 32'd0);
    check("t6_async_ready", {31'd0, req_ready}, 32'd1);
    exp_q.delete();
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      check("t6_post_rst", {29'd0, plot, req_ready, done}, 32'b010);
    end
    send("t6b", 5, 5, 1, 1, 3'b101);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/rect_plotter.md
Name: rect_plotter

Overview:
- Pixel-stream generator that sits directly upstream of the VGA adapter in the 160x120, 3-bit-colour display path.
- Accepts one rectangle-fill request at a time over a valid/ready handshake.
- Emits one pixel per clock on x/y/colour/plot, row-major, clipped to the screen, then pulses done.
- Game logic uses it both for screen clears and for drawing boxers and health bars.

Parameters:
SCREEN_W  160  visible width in pixels; x outputs never reach or exceed this
SCREEN_H  120  visible height in pixels; y outputs never reach or exceed this

Ports:
clock       input   1  system clock (50 MHz)
reset       input   1  asynchronous, active-high reset
req_valid   input   1  request present
req_ready   output  1  block can accept a request (high only in IDLE)
req_x       input   8  rectangle left column
req_y       input   7  rectangle top row
req_w       input   8  width in pixels
req_h       input   7  height in pixels
req_colour  input   3  fill colour, {R,G,B}
x           output  8  pixel column to adapter
y           output  7  pixel row to adapter
colour      output  3  pixel colour to adapter
plot        output  1  write strobe to adapter, one pixel per high cycle
done        output  1  one-cycle pulse when a request completes

Behaviour:
- Reset is asynchronous and active-high. It forces state IDLE and x=0, y=0, colour=0, plot=0, done=0. req_ready=1 while in IDLE.
- Reset during DRAW aborts immediately: plot drops asynchronously, no done pulse, and the request is discarded.
- All outputs except req_ready are registered. req_ready is decoded from the state register (state==IDLE).
- States:
  - IDLE: req_ready=1, plot=0. On req_valid && req_ready at an edge, latch req_x, req_y, req_colour and compute clipped bounds:
    - x_end = min(req_x+req_w, SCREEN_W) - 1, computed in 9 bits.
    - y_end = min(req_y+req_h, SCREEN_H) - 1, computed in 8 bits.
    - If req_w==0, req_h==0, req_x>=SCREEN_W or req_y>=SCREEN_H, go to DONE with no pixels plotted.
    - Otherwise load x=req_x, y=req_y, colour=req_colour, set plot=1 and go to DRAW.
  - DRAW: plot=1 every cycle, and each cycle presents exactly one pixel.
    - Next pixel: if x<x_end then x+1; else x returns to the latched left column and y+1.
    - When x==x_end and y==y_end on the current cycle, the next edge sets plot=0, done=1 and moves to DONE.
  - DONE: done=1 for exactly this one cycle and req_ready=0. The next edge returns to IDLE with done=0.
- Timing:
  - Accept edge k gives the first pixel visible in cycle k+1.
  - An N-pixel rectangle occupies cycles k+1..k+N with plot high.
  - done is high in cycle k+N+1, and req_ready rises in cycle k+N+2.
  - For an empty request, done is high in cycle k+1.
- Back-to-back: a request held valid during DONE is accepted on the first IDLE edge. Minimum gap is 2 cycles with plot low between rectangles.
- req_* inputs are ignored outside IDLE; the latched values stay stable for the whole draw.
- x, y and colour hold their last values while plot=0.
- Maximum request is the full screen, 19200 pixels. No counter may wrap past SCREEN_W-1 or SCREEN_H-1.

Test Plan:
1. Reset, then request (10,20) w=3 h=2 colour=3'b100 -> plot high 6 consecutive cycles with pixels (10,20),(11,20),(12,20),(10,21),(11,21),(12,21), all colour 100. done pulses the next cycle; req_ready is low from the accept until 2 cycles after the last pixel.
2. Clip: (158,118) w=5 h=5 colour=3'b010 -> exactly 4 pixels: (158,118),(159,118),(158,119),(159,119), then done. x never exceeds 159 and y never exceeds 119.
3. Full clear: (0,0) w=160 h=120 colour=3'b000 -> 19200 plot cycles, first pixel (0,0), row 0 ends at (159,0) followed by (0,1), last pixel (159,119), then done.
4. Degenerate requests: w=0; then h=0; then x=200 -> no plot cycle, done high in the cycle after acceptance for each.
5. Busy and back-to-back: req_valid held high continuously with changing req_* values during a 4x1 draw -> the in-flight rectangle is unchanged, the second request is accepted exactly when req_ready is 1, and plot stays low for 2 cycles between rectangles.
6. Reset mid-draw: assert reset after the 3rd pixel of an 8x8 draw -> plot=0 immediately (asynchronously), no done pulse. After release, req_ready=1, and a new 1x1 request at (5,5) produces the single pixel (5,5).
